// File: rtl/afe_spi_pkg.sv
// Shared constants and FSM state encoding for the AFE SPI master.
package afe_spi_pkg;

  localparam int MAX_BITS = 32;
  localparam int LEN_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

endpackage

// File: rtl/afe_spi_master_if.sv
// Transfer request/response bus plus SPI pins of the AFE SPI master.
// The master modport is the controller view; slave is the requester/peer view.
interface afe_spi_master_if import afe_spi_pkg::*; ();

  logic                start;
  logic [LEN_W-1:0]    len;
  logic [MAX_BITS-1:0] tx_data;
  logic [MAX_BITS-1:0] rx_data;
  logic                busy;
  logic                done;
  logic                sclk;
  logic                cs_b;
  logic                mosi;
  logic                miso;

  modport master (
    input  start, len, tx_data, miso,
    output rx_data, busy, done, sclk, cs_b, mosi
  );

  modport slave (
    output start, len, tx_data, miso,
    input  rx_data, busy, done, sclk, cs_b, mosi
  );

endinterface

// File: rtl/afe_spi_tick.sv
// Phase counter 0..CLK_DIV-1; tc_o marks the last cycle of a timed state.
module afe_spi_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/afe_spi_master.sv
// SPI mode-0 master, MSB first, 1..MAX_BITS bits per CS_B frame.
// Optional AFE_SPI_MASTER_LOOPBACK_EN adds loopback_i (sample MOSI instead of MISO).
module afe_spi_master import afe_spi_pkg::*; #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef AFE_SPI_MASTER_LOOPBACK_EN
  input  logic loopback_i,
`endif
  afe_spi_master_if.master bus_if
);

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] tx_q, tx_d;
  logic [MAX_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [MAX_BITS-1:0] rx_data_q, rx_data_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                sclk_q, sclk_d;
  logic                cs_b_q, cs_b_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                tc_s;
  logic                tick_clr_s;
  logic                len_ok_s;
  logic                sample_s;
  logic [MAX_BITS-1:0] tx_aligned_s;

  afe_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tick_clr_s),
    .tc_o  (tc_s)
  );

  assign len_ok_s     = (bus_if.len != {LEN_W{1'b0}}) && (bus_if.len <= LEN_W'(MAX_BITS));
  // Left-align so the first bit to send always sits in the MSB.
  assign tx_aligned_s = bus_if.tx_data << (LEN_W'(MAX_BITS) - bus_if.len);

`ifdef AFE_SPI_MASTER_LOOPBACK_EN
  assign sample_s = loopback_i ? mosi_q : bus_if.miso;
`else
  assign sample_s = bus_if.miso;
`endif

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    cs_b_d     = cs_b_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    tick_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_clr_s = 1'b1;
        if (bus_if.start && len_ok_s) begin
          tx_d      = tx_aligned_s;
          rx_sh_d   = '0;
          bit_cnt_d = bus_if.len;
          cs_b_d    = 1'b0;
          mosi_d    = tx_aligned_s[MAX_BITS-1];
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (tc_s) begin
          sclk_d    = 1'b1;
          rx_sh_d   = {rx_sh_q[MAX_BITS-2:0], sample_s};
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          state_d   = ST_HIGH;
        end else begin
          state_d   = state_q;
        end
      end
      ST_HIGH: begin
        if (tc_s) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != {LEN_W{1'b0}}) begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[MAX_BITS-2];
            state_d = ST_LOW;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (tc_s) begin
          cs_b_d    = 1'b1;
          mosi_d    = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = ST_GAP;
        end else begin
          state_d   = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (tc_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        cs_b_d  = 1'b1;
        mosi_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_b_q    <= 1'b1;
      mosi_q    <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_b_q    <= cs_b_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus_if.rx_data = rx_data_q;
  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.sclk    = sclk_q;
  assign bus_if.cs_b    = cs_b_q;
  assign bus_if.mosi    = mosi_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Directed bench for afe_spi_master with a mode-0 slave model (shifts on SCLK fall).
module tb_afe_spi_master;

  logic clk;
  logic rst;
`ifdef AFE_SPI_MASTER_LOOPBACK_EN
  logic loopback;
`endif

  afe_spi_master_if ifc();

  afe_spi_master #(.CLK_DIV(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef AFE_SPI_MASTER_LOOPBACK_EN
    .loopback_i (loopback),
`endif
    .bus_if     (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Slave model: loads its MSB at CS_B fall, steps to the next bit on each SCLK fall.
  logic [31:0] slv_word = 32'h0;
  int          slv_len  = 1;
  int          slv_idx  = 0;
  logic        cs_prev  = 1'b1;
  logic        sclk_prev = 1'b0;
  assign ifc.miso = slv_word[slv_idx];

  always @(ifc.cs_b, ifc.sclk) begin
    if (cs_prev === 1'b1 && ifc.cs_b === 1'b0) slv_idx = slv_len - 1;
    else if (sclk_prev === 1'b1 && ifc.sclk === 1'b0 && ifc.cs_b === 1'b0 && slv_idx > 0)
      slv_idx = slv_idx - 1;
    cs_prev   = ifc.cs_b;
    sclk_prev = ifc.sclk;
  end

  logic [31:0] mosi_log = 32'h0;
  int          rises    = 0;
  always @(posedge ifc.sclk) begin
    mosi_log <= {mosi_log[30:0], ifc.mosi};
    rises    <= rises + 1;
  end

  int cs_low_cnt = 0;
  int busy_cnt   = 0;
  int done_cnt   = 0;
  always @(negedge clk) begin
    if (ifc.cs_b === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
    if (ifc.busy === 1'b1) busy_cnt   <= busy_cnt + 1;
    if (ifc.done === 1'b1) done_cnt   <= done_cnt + 1;
  end

  int s_rises, s_cs, s_busy, s_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_rises = rises;
    s_cs    = cs_low_cnt;
    s_busy  = busy_cnt;
    s_done  = done_cnt;
  endtask

  task automatic start_xfer(input logic [5:0] l, input logic [31:0] tx, input logic [31:0] sw);
    slv_word    = sw;
    slv_len     = (l == 6'd0) ? 1 : int'(l);
    ifc.len     = l;
    ifc.tx_data = tx;
    ifc.start   = 1'b1;
    tick();
    ifc.start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (ifc.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, ifc.busy}, 32'd0);
    tick();
  endtask

  initial begin
    int done_edge;
    int busy_edge;
    rst         = 1'b1;
    ifc.start   = 1'b0;
    ifc.len     = 6'd0;
    ifc.tx_data = 32'h0;
`ifdef AFE_SPI_MASTER_LOOPBACK_EN
    loopback    = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst_cs_b", {31'd0, ifc.cs_b}, 32'd1);
    check_eq("rst_sclk", {31'd0, ifc.sclk}, 32'd0);
    check_eq("rst_mosi", {31'd0, ifc.mosi}, 32'd1);
    check_eq("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check_eq("rst_done", {31'd0, ifc.done}, 32'd0);
    check_eq("rst_rx",   ifc.rx_data,       32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // LEN=8, 0xA5 out, 0x3C in, with edge-accurate timing
    snap();
    start_xfer(6'd8, 32'h0000_00A5, 32'h0000_003C);
    check_eq("t1_cs_low_e0", {31'd0, ifc.cs_b}, 32'd0);
    check_eq("t1_mosi_e0",   {31'd0, ifc.mosi}, 32'd1);
    check_eq("t1_busy_e0",   {31'd0, ifc.busy}, 32'd1);
    done_edge = -1;
    busy_edge = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 1) check_eq("t1_sclk_e1", {31'd0, ifc.sclk}, 32'd0);
      if (e == 2) check_eq("t1_sclk_e2", {31'd0, ifc.sclk}, 32'd1);
      if (ifc.done === 1'b1 && done_edge < 0) done_edge = e;
      if (ifc.busy === 1'b0 && busy_edge < 0) busy_edge = e;
    end
    check_eq("t1_done_edge", done_edge, 32'd34);
    check_eq("t1_busy_edge", busy_edge, 32'd36);
    check_eq("t1_rx",        ifc.rx_data, 32'h0000_003C);
    check_eq("t1_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h0000_00A5);
    check_eq("t1_rises",     rises - s_rises, 32'd8);
    check_eq("t1_done_cnt",  done_cnt - s_done, 32'd1);

    // LEN=16 frame length and data
    snap();
    start_xfer(6'd16, 32'h0000_1234, 32'h0000_BEEF);
    wait_idle("t2_timeout", 200);
    check_eq("t2_rx",        ifc.rx_data, 32'h0000_BEEF);
    check_eq("t2_mosi_bits", {16'd0, mosi_log[15:0]}, 32'h0000_1234);
    check_eq("t2_rises",     rises - s_rises, 32'd16);
    check_eq("t2_cs_low",    cs_low_cnt - s_cs, 32'd66);
    check_eq("t2_busy_len",  busy_cnt - s_busy, 32'd68);

    // Illegal lengths are ignored
    snap();
    start_xfer(6'd0, 32'hFFFF_FFFF, 32'h0);
    repeat (4) tick();
    start_xfer(6'd33, 32'hFFFF_FFFF, 32'h0);
    repeat (10) tick();
    check_eq("t3_cs_low", cs_low_cnt - s_cs, 32'd0);
    check_eq("t3_busy",   busy_cnt - s_busy, 32'd0);
    check_eq("t3_done",   done_cnt - s_done, 32'd0);
    check_eq("t3_rx_hold", ifc.rx_data, 32'h0000_BEEF);

    // START during a transfer is dropped, not queued
    snap();
    start_xfer(6'd8, 32'h0000_00A5, 32'h0000_003C);
    repeat (9) tick();
    ifc.tx_data = 32'h0000_00FF;
    ifc.start   = 1'b1;
    tick();
    ifc.start   = 1'b0;
    wait_idle("t4_timeout", 200);
    repeat (20) tick();
    check_eq("t4_rx",        ifc.rx_data, 32'h0000_003C);
    check_eq("t4_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h0000_00A5);
    check_eq("t4_done_cnt",  done_cnt - s_done, 32'd1);
    check_eq("t4_busy_len",  busy_cnt - s_busy, 32'd36);

    // Reset at edge 10 of an LEN=8 transfer
    snap();
    start_xfer(6'd8, 32'h0000_0081, 32'h0000_0042);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check_eq("t5_cs_b", {31'd0, ifc.cs_b}, 32'd1);
    check_eq("t5_sclk", {31'd0, ifc.sclk}, 32'd0);
    check_eq("t5_mosi", {31'd0, ifc.mosi}, 32'd1);
    check_eq("t5_busy", {31'd0, ifc.busy}, 32'd0);
    check_eq("t5_rx",   ifc.rx_data,       32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_eq("t5_no_done", done_cnt - s_done, 32'd0);
    snap();
    start_xfer(6'd8, 32'h0000_005A, 32'h0000_00C3);
    wait_idle("t5b_timeout", 200);
    check_eq("t5b_rx",        ifc.rx_data, 32'h0000_00C3);
    check_eq("t5b_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h0000_005A);
    check_eq("t5b_done_cnt",  done_cnt - s_done, 32'd1);

    // Full-width LEN=32 frame
    snap();
    start_xfer(6'd32, 32'hCAFE_F00D, 32'h8765_4321);
    wait_idle("t6_timeout", 400);
    check_eq("t6_rx",        ifc.rx_data, 32'h8765_4321);
    check_eq("t6_mosi_bits", mosi_log, 32'hCAFE_F00D);
    check_eq("t6_cs_low",    cs_low_cnt - s_cs, 32'd130);

`ifdef AFE_SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    start_xfer(6'd32, 32'hDEAD_BEEF, 32'h0);
    wait_idle("t7_timeout", 400);
    check_eq("t7_loopback_rx", ifc.rx_data, 32'hDEAD_BEEF);
    loopback = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
